// File: rtl/systolic_pkg.sv
// systolic_pkg
// Shared definitions for the output-stationary integer systolic array:
//   - default array geometry and field widths
//   - FSM state encoding (IDLE/FEED/FLUSH/DRAIN)
//   - product width helper used by every PE
package systolic_pkg;

  localparam int DEF_N  = 16;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 32;
  localparam int DEF_KW = 16;

  // Control FSM states, kept as plain constants so older tools that
  // do not handle enums in ports and arrays still accept them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FEED  = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_DRAIN = 2'd3;

  // One extra bit beyond 2*DW holds both the full signed range and the
  // full unsigned range of a DW x DW product.
  function automatic int prod_width(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/pe_mac_os.sv
// pe_mac_os
// One output-stationary processing element. The operands pass straight
// through one register stage to the right/down neighbours while the
// local accumulator adds their product every cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   a_in, b_in   operands arriving from the left / from above
//   clr          synchronous clear of accumulator and pass-through regs
//   sgn          1 = operands are two's complement, 0 = unsigned
//   a_out, b_out registered copies of a_in / b_in
//   acc          running accumulator (wraps modulo 2^AW)
module pe_mac_os
  import systolic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic          clr,
  input  logic          sgn,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  localparam int PW = prod_width(DW);

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;

  logic signed [DW:0]   a_ext;
  logic signed [DW:0]   b_ext;
  logic signed [PW-1:0] prod;

  // The extra top bit turns both modes into one signed multiply: it
  // copies the sign bit in signed mode and is zero in unsigned mode.
  // The size cast on the product sign-extends (or truncates) it to the
  // accumulator width, so accumulation simply wraps.
  always_comb begin
    a_ext = {sgn & a_in[DW-1], a_in};
    b_ext = {sgn & b_in[DW-1], b_in};
    prod  = PW'(a_ext) * PW'(b_ext);
    a_d   = a_in;
    b_d   = b_in;
    acc_d = acc_q + AW'(prod);
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_os_int.sv
// systolic_os_int
// Output-stationary N x N integer matrix-multiply engine. Operand beats
// (one column of A, one row of B) arrive on a valid/ready stream, are
// skewed internally and swept through a grid of pe_mac_os cells. After
// k_len beats the array is flushed for 2N-1 cycles and the results are
// drained one row per out_valid/out_ready handshake.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start, k_len,
//   signed_mode            tile start request and its settings (IDLE only)
//   in_valid, in_ready,
//   a_col, b_row           operand beat stream
//   out_valid, out_ready,
//   out_row, out_row_idx   result row stream
//   busy                   high whenever not IDLE
//   done                   one-cycle pulse after the last row handshake
module systolic_os_int
  import systolic_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int KW = DEF_KW,
  localparam int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            signed_mode,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW*N-1:0] a_col,
  input  logic [DW*N-1:0] b_row,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW*N-1:0] out_row,
  output logic [RW-1:0]   out_row_idx,
  output logic            busy,
  output logic            done
);

  localparam int FW = $clog2(2 * N);

  state_t        state_q, state_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          sgn_q, sgn_d;
  logic          done_q, done_d;

  logic          clr;
  logic          beat_fire;

  logic [N-1:0][DW-1:0]         a_inj, b_inj;
  logic [N-1:0][DW-1:0]         a_edge, b_edge;
  logic [N-1:0][N-1:0][DW-1:0]  a_out_w, b_out_w;
  logic [N-1:0][N-1:0][AW-1:0]  acc_all;
  logic [N-1:0][DW-1:0]         a_tail_unused, b_tail_unused;

  assign in_ready  = (state_q == ST_FEED);
  assign out_valid = (state_q == ST_DRAIN);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign beat_fire = in_valid & in_ready;

  // Control FSM. The flush counter runs 0..2N-2, which gives the last
  // beat time to reach PE(N-1,N-1) through both skew paths. The clear
  // on start wipes the previous tile so accumulators can hold their
  // results in IDLE until then.
  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    sgn_d       = sgn_q;
    done_d      = 1'b0;
    clr         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr         = 1'b1;
          k_cnt_d     = k_len;
          sgn_d       = signed_mode;
          flush_cnt_d = '0;
          row_d       = '0;
          state_d     = (k_len == '0) ? ST_FLUSH : ST_FEED;
        end
      end
      ST_FEED: begin
        if (beat_fire) begin
          k_cnt_d = k_cnt_q - KW'(1);
          if (k_cnt_q == KW'(1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FW'(2 * N - 2)) begin
          flush_cnt_d = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      sgn_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      sgn_q       <= sgn_d;
      done_q      <= done_d;
    end
  end

  // Cycles without a handshake inject zeros, so the array never has to
  // stall: a zero operand contributes nothing to any accumulator.
  assign a_inj = beat_fire ? a_col : '0;
  assign b_inj = beat_fire ? b_row : '0;

  // Triangular skew front end: lane i of A and lane j of B are delayed
  // by i and j cycles so that matching k values meet in every PE.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_edge[0] = a_inj[0];
      assign b_edge[0] = b_inj[0];
    end else begin : g_delay
      logic [DW-1:0] a_line_q [gi];
      logic [DW-1:0] a_line_d [gi];
      logic [DW-1:0] b_line_q [gi];
      logic [DW-1:0] b_line_d [gi];

      always_comb begin
        a_line_d[0] = a_inj[gi];
        b_line_d[0] = b_inj[gi];
        for (int s = 1; s < gi; s++) begin
          a_line_d[s] = a_line_q[s-1];
          b_line_d[s] = b_line_q[s-1];
        end
        if (clr) begin
          for (int s = 0; s < gi; s++) begin
            a_line_d[s] = '0;
            b_line_d[s] = '0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < gi; s++) begin
            a_line_q[s] <= '0;
            b_line_q[s] <= '0;
          end
        end else begin
          for (int s = 0; s < gi; s++) begin
            a_line_q[s] <= a_line_d[s];
            b_line_q[s] <= b_line_d[s];
          end
        end
      end

      assign a_edge[gi] = a_line_q[gi-1];
      assign b_edge[gi] = b_line_q[gi-1];
    end
  end

  // PE grid: A travels right along a row, B travels down a column.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] a_in_w, b_in_w;

      if (gj == 0) begin : g_a_edge
        assign a_in_w = a_edge[gi];
      end else begin : g_a_link
        assign a_in_w = a_out_w[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in_w = b_edge[gj];
      end else begin : g_b_link
        assign b_in_w = b_out_w[gi-1][gj];
      end

      pe_mac_os #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk  (clk),
        .rst_n(rst_n),
        .a_in (a_in_w),
        .b_in (b_in_w),
        .clr  (clr),
        .sgn  (sgn_q),
        .a_out(a_out_w[gi][gj]),
        .b_out(b_out_w[gi][gj]),
        .acc  (acc_all[gi][gj])
      );
    end
  end

  // The last column/row pass-through outputs have no neighbour to feed.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_tail_unused[i] = a_out_w[i][N-1];
      b_tail_unused[i] = b_out_w[N-1][i];
    end
  end

  // Row mux; the bus reads zero whenever no row is being offered.
  assign out_row     = out_valid ? acc_all[row_q] : '0;
  assign out_row_idx = row_q;

endmodule

// File: tb/tb_systolic_os_int.sv
// tb_systolic_os_int
// Directed bench for systolic_os_int. Two N=4 instances share all inputs:
// dut_a uses a 32-bit accumulator, dut_w a 16-bit one so wrap-around is
// visible on the same stimulus.
module tb_systolic_os_int;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int KW  = 16;
  localparam int AW  = 32;
  localparam int AWW = 16;
  localparam int RW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            in_valid;
  logic [DW*N-1:0] a_col;
  logic [DW*N-1:0] b_row;
  logic            out_ready;

  logic             in_ready_a, out_valid_a, busy_a, done_a;
  logic [AW*N-1:0]  out_row_a;
  logic [RW-1:0]    idx_a;
  logic             in_ready_w, out_valid_w, busy_w, done_w;
  logic [AWW*N-1:0] out_row_w;
  logic [RW-1:0]    idx_w;

  systolic_os_int #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready_a),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_row(out_row_a), .out_row_idx(idx_a),
    .busy(busy_a), .done(done_a)
  );

  systolic_os_int #(.N(N), .DW(DW), .AW(AWW), .KW(KW)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_col(a_col), .b_row(b_row), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_row(out_row_w), .out_row_idx(idx_w),
    .busy(busy_w), .done(done_w)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     start_cyc;
  int     a_mat [N][16];
  int     b_mat [16][N];
  longint exp_c [N][N];

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  function automatic logic [DW*N-1:0] packA(input int k);
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = a_mat[i][k][7:0];
    return v;
  endfunction

  function automatic logic [DW*N-1:0] packB(input int k);
    logic [DW*N-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = b_mat[k][j][7:0];
    return v;
  endfunction

  function automatic int opVal(input int v, input bit s);
    logic [7:0] e;
    e = v[7:0];
    if (s && e[7]) return int'(e) - 256;
    return int'(e);
  endfunction

  function automatic logic [127:0] expRow32(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*32 +: 32] = exp_c[r][j][31:0];
    return v;
  endfunction

  function automatic logic [127:0] expRow16(input int r);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*16 +: 16] = exp_c[r][j][15:0];
    return v;
  endfunction

  task automatic setAll(input longint v);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) exp_c[i][j] = v;
  endtask

  task automatic fillConst(input int av, input int bv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        a_mat[i][k] = av;
        b_mat[k][i] = bv;
      end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        a_mat[i][k] = int'($urandom_range(0, 255));
        b_mat[k][i] = int'($urandom_range(0, 255));
      end
  endtask

  task automatic computeModel(input bit s, input int klen);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int k = 0; k < klen; k++)
          exp_c[i][j] += longint'(opVal(a_mat[i][k], s) * opVal(b_mat[k][j], s));
      end
  endtask

  task automatic checkResetState(input string p);
    checkOutput({p, "_in_ready"},  in_ready_a,  1'b0);
    checkOutput({p, "_out_valid"}, out_valid_a, 1'b0);
    checkOutput({p, "_busy"},      busy_a,      1'b0);
    checkOutput({p, "_done"},      done_a,      1'b0);
    checkOutput({p, "_out_row"},   out_row_a,   '0);
    checkOutput({p, "_idx"},       idx_a,       '0);
    checkOutput({p, "_busy_w"},    busy_w,      1'b0);
    checkOutput({p, "_in_ready_w"}, in_ready_w, 1'b0);
    checkOutput({p, "_out_row_w"}, out_row_w,   '0);
  endtask

  // Drives start on a negedge and returns on the negedge after it is sampled.
  task automatic startTile(input int klen, input bit sgn);
    start       = 1'b1;
    k_len       = KW'(klen);
    signed_mode = sgn;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy_a, 1'b1);
    checkOutput("in_ready_after_start", in_ready_a, klen != 0);
  endtask

  task automatic feedBeats(input int klen, input bit bubbles, input bit poke);
    int  beat;
    int  budget;
    bit  v;
    beat   = 0;
    budget = 0;
    while (beat < klen && budget < 500) begin
      v        = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      a_col    = packA(beat);
      b_row    = packB(beat);
      if (poke) start = 1'($urandom_range(0, 1));
      if (v && in_ready_a) beat++;
      @(negedge clk);
      budget++;
    end
    if (beat < klen) checkOutput("feed_timeout", 128'(beat), 128'(klen));
    start    = 1'b0;
    in_valid = 1'b1;
    a_col    = '1;
    b_row    = '1;
    checkOutput("in_ready_drop", in_ready_a, 1'b0);
  endtask

  task automatic waitOutValid(input int exp_lat);
    int waited;
    waited = 0;
    while (!out_valid_a && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid_a) checkOutput("out_valid_timeout", out_valid_a, 1'b1);
    else if (exp_lat >= 0) checkOutput("latency", 128'(cyc - start_cyc), 128'(exp_lat));
  endtask

  task automatic drainRows(input int stall, input bit poke);
    for (int r = 0; r < N; r++) begin
      for (int s = 0; s < stall; s++) begin
        out_ready = 1'b0;
        if (poke) start = 1'($urandom_range(0, 1));
        checkOutput($sformatf("stall_row%0d_s%0d", r, s), out_row_a, expRow32(r));
        checkOutput($sformatf("stall_idx%0d_s%0d", r, s), idx_a, 128'(r));
        @(negedge clk);
      end
      out_ready = 1'b1;
      start     = 1'b0;
      checkOutput($sformatf("out_valid_r%0d", r), out_valid_a, 1'b1);
      checkOutput($sformatf("idx_r%0d", r), idx_a, 128'(r));
      checkOutput($sformatf("row32_r%0d", r), out_row_a, expRow32(r));
      checkOutput($sformatf("row16_r%0d", r), out_row_w, expRow16(r));
      @(negedge clk);
    end
    checkOutput("done_pulse", done_a, 1'b1);
    checkOutput("done_pulse_w", done_w, 1'b1);
    checkOutput("busy_at_done", busy_a, 1'b0);
    checkOutput("out_valid_at_done", out_valid_a, 1'b0);
    @(negedge clk);
    checkOutput("done_clear", done_a, 1'b0);
    checkOutput("idle_busy", busy_a, 1'b0);
  endtask

  task automatic applyStimulus(input int klen, input bit sgn, input bit bubbles,
                               input int stall, input bit poke);
    startTile(klen, sgn);
    feedBeats(klen, bubbles, poke);
    out_ready = (stall == 0);
    waitOutValid(bubbles ? -1 : klen + 2 * N);
    drainRows(stall, poke);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    k_len       = '0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    a_col       = '0;
    b_row       = '0;
    out_ready   = 1'b1;
    repeat (2) @(negedge clk);
    checkResetState("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Identity A: each result row equals the matching row of B.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 16; k++) begin
        a_mat[i][k] = (i == k) ? 1 : 0;
        b_mat[k][i] = 0;
      end
    for (int k = 0; k < N; k++)
      for (int j = 0; j < N; j++) b_mat[k][j] = k * 4 + j;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) exp_c[r][j] = longint'(r * 4 + j);
    applyStimulus(4, 1'b1, 1'b0, 0, 1'b0);

    // -128 x -128 over 16 beats: 16 * 16384 in both modes.
    fillConst(-128, -128);
    setAll(262144);
    applyStimulus(16, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(16, 1'b0, 1'b0, 0, 1'b0);

    // -1 x 1: -16 signed, 255 * 16 unsigned.
    fillConst(-1, 1);
    setAll(-16);
    applyStimulus(16, 1'b1, 1'b0, 0, 1'b0);
    setAll(4080);
    applyStimulus(16, 1'b0, 1'b0, 0, 1'b0);

    // 255 x 255 over 2 beats: 130050, i.e. 64514 in a 16-bit accumulator.
    fillConst(255, 255);
    setAll(130050);
    applyStimulus(2, 1'b0, 1'b0, 0, 1'b0);

    // Random data with input bubbles, output backpressure and stray starts.
    fillRandom();
    computeModel(1'b1, 6);
    applyStimulus(6, 1'b1, 1'b1, 3, 1'b1);

    // Empty tile: straight to flush, then N zero rows.
    setAll(0);
    applyStimulus(0, 1'b1, 1'b0, 0, 1'b0);

    // Abort mid-FEED.
    fillRandom();
    startTile(8, 1'b1);
    for (int b = 0; b < 3; b++) begin
      in_valid = 1'b1;
      a_col    = packA(b);
      b_row    = packB(b);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("rst_feed");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    // Abort mid-DRAIN while the first row is being held.
    startTile(3, 1'b0);
    feedBeats(3, 1'b0, 1'b0);
    out_ready = 1'b0;
    waitOutValid(-1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState("rst_drain");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    // A fresh tile after the aborts.
    fillRandom();
    computeModel(1'b0, 5);
    applyStimulus(5, 1'b0, 1'b0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
